// File: rtl/data_mem_if.sv
// Load/store request/response bus between the CPU MEM stage (master) and
// the data memory responder (slave).
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both high; a response transfers on a rising edge where
// rsp_valid and rsp_ready are both high. Once rsp_valid is raised it stays
// high, with rsp_rdata/rsp_err unchanged, until that transfer happens.
// Request fields only need to be valid in the accepting cycle.
interface data_mem_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory responder: DEPTH x 8-bit array served one access at a time
// through the data_mem_if slave port, with WAIT_CYCLES wait states between
// request acceptance and the array access.
module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  data_mem_if.slave  bus,
  output logic [1:0] state_dbg
);

  // Index width; a single-word array still needs one index bit.
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            access;
  logic            rsp_done;
  logic            req_ready_c;
  logic            rsp_valid_c;

  logic [3:0]      cnt;
  logic            we_q;
  logic [7:0]      addr_q;
  logic [7:0]      wdata_q;
  logic [7:0]      rdata_q;
  logic            err_q;

  logic            in_range;
  logic [AW-1:0]   idx;
  logic [7:0]      mem [DEPTH];

  // The range check uses the full latched address; only after it passes do
  // the low index bits select a word, so aliased out-of-range addresses
  // never touch the array.
  assign in_range = ({1'b0, addr_q} < 9'(DEPTH));
  assign idx      = addr_q[AW-1:0];

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake outputs.
  always_comb begin
    state_next  = state;
    req_ready_c = 1'b0;
    rsp_valid_c = 1'b0;
    accept      = 1'b0;
    access      = 1'b0;
    rsp_done    = 1'b0;
    case (state)
      IDLE: begin
        req_ready_c = 1'b1;
        if (bus.req_valid) begin
          accept     = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access     = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        // A request seen here is not accepted until the cycle after the
        // response leaves, since req_ready is low for the whole of RESP.
        rsp_valid_c = 1'b1;
        if (bus.rsp_ready) begin
          rsp_done   = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture, wait-state counter and response registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 8'd0;
      wdata_q <= 8'd0;
      rdata_q <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        cnt     <= 4'(WAIT_CYCLES);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end

      if (access) begin
        rdata_q <= (in_range && !we_q) ? mem[idx] : 8'd0;
        err_q   <= !in_range;
      end else if (rsp_done) begin
        rdata_q <= 8'd0;
        err_q   <= 1'b0;
      end
    end
  end

  // Storage array; reset wipes every word so an interrupted store is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'd0;
      end
    end else if (access && in_range && we_q) begin
      mem[idx] <= wdata_q;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_c;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance with WAIT_CYCLES=2 and one with
// WAIT_CYCLES=0 share a single driver, selected by sel. Expected responses
// are queued as requests are accepted; a negedge monitor pops and compares.
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  logic       sel = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_we = 1'b0;
  logic [7:0] req_addr = 8'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       rsp_ready = 1'b1;

  logic [1:0] dbg2;
  logic [1:0] dbg0;

  data_mem_if bus2 ();
  data_mem_if bus0 ();

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus(bus2), .state_dbg(dbg2)
  );
  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .state_dbg(dbg0)
  );

  assign bus2.req_valid = req_valid && !sel;
  assign bus2.req_we    = req_we;
  assign bus2.req_addr  = req_addr;
  assign bus2.req_wdata = req_wdata;
  assign bus2.rsp_ready = sel ? 1'b1 : rsp_ready;
  assign bus0.req_valid = req_valid && sel;
  assign bus0.req_we    = req_we;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_wdata = req_wdata;
  assign bus0.rsp_ready = sel ? rsp_ready : 1'b1;

  logic       m_req_ready;
  logic       m_rsp_valid;
  logic [7:0] m_rdata;
  logic       m_err;
  int         w_cur;
  assign m_req_ready = sel ? bus0.req_ready : bus2.req_ready;
  assign m_rsp_valid = sel ? bus0.rsp_valid : bus2.rsp_valid;
  assign m_rdata     = sel ? bus0.rsp_rdata : bus2.rsp_rdata;
  assign m_err       = sel ? bus0.rsp_err   : bus2.rsp_err;
  assign w_cur       = sel ? 0 : 2;

  // Clock and edge counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard state.
  logic [8:0] exp_q[$];
  int         acc_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         last_hs = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] hold_data = 8'd0;
  logic       hold_err = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one request and wait (bounded) for it to be accepted.
  task automatic issue(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                       input logic [8:0] exp, output int acc);
    int budget;
    budget = 0;
    acc = -1;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    while (!m_req_ready && budget < 50) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!m_req_ready) begin
      check("accept_timeout", 0, 1);
    end else begin
      acc = cyc + 1;
      exp_q.push_back(exp);
      acc_q.push_back(acc);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while (exp_q.size() != 0 && budget < 100) begin
      @(posedge clk); #1;
      budget++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  // Response monitor: latency on rise, stability while held, data on transfer.
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else if (m_rsp_valid) begin
      if (!prev_valid) begin
        if (acc_q.size() == 0) check("unexpected_rsp", 1, 0);
        else check("rsp_latency", cyc - acc_q[0], w_cur + 1);
      end else begin
        check("hold_rdata", m_rdata, hold_data);
        check("hold_err", m_err, hold_err);
      end
      hold_data = m_rdata;
      hold_err  = m_err;
      if (rsp_ready) begin
        if (exp_q.size() != 0) begin
          check("rsp_data", {m_err, m_rdata}, exp_q.pop_front());
          void'(acc_q.pop_front());
        end
        last_hs = cyc + 1;
        prev_valid = 1'b0;
      end else begin
        prev_valid = 1'b1;
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // Directed stimulus.
  initial begin
    int a1, a2, budget;
    int acc_arr[4];

    // Reset state of both instances.
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready2", bus2.req_ready, 1);
    check("rst_rsp_valid2", bus2.rsp_valid, 0);
    check("rst_rdata2", bus2.rsp_rdata, 0);
    check("rst_err2", bus2.rsp_err, 0);
    check("rst_state2", dbg2, 0);
    check("rst_req_ready0", bus0.req_ready, 1);
    rst = 1'b0;

    // 1: reset mid-WAIT of a store of 0xAA to addr 5.
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 8'd5; req_wdata = 8'hAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("t1_in_wait", dbg2, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    check("t1_req_ready", bus2.req_ready, 1);
    check("t1_rsp_valid", bus2.rsp_valid, 0);
    check("t1_rdata", bus2.rsp_rdata, 0);
    check("t1_err", bus2.rsp_err, 0);
    check("t1_state", dbg2, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(1'b0, 8'd5, 8'd0, 9'h000, a1);

    // 2: store 0x3C to addr 10, then load it back.
    issue(1'b1, 8'd10, 8'h3C, 9'h000, a1);
    issue(1'b0, 8'd10, 8'd0, 9'h03C, a2);
    check("t2_spacing", a2 - a1, 5);

    // 3: out-of-range load/store; aliased word 0 must stay untouched.
    issue(1'b0, 8'h80, 8'd0, 9'h100, a1);
    issue(1'b1, 8'h40, 8'h77, 9'h100, a1);
    issue(1'b0, 8'd0, 8'd0, 9'h000, a1);
    issue(1'b0, 8'd10, 8'd0, 9'h03C, a1);
    issue(1'b1, 8'd63, 8'h5A, 9'h000, a1);
    issue(1'b0, 8'd63, 8'd0, 9'h05A, a1);
    wait_drain();

    // 4 and 6: backpressure for 5 cycles with a competing request pending.
    rsp_ready = 1'b0;
    issue(1'b0, 8'd10, 8'd0, 9'h03C, a1);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'd63; req_wdata = 8'd0;
    budget = 0;
    while (!m_rsp_valid && budget < 20) begin
      @(posedge clk); #1;
      budget++;
    end
    check("t4_rsp_seen", m_rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("t4_req_ready_low", m_req_ready, 0);
      check("t4_rsp_valid_held", m_rsp_valid, 1);
    end
    rsp_ready = 1'b1;
    issue(1'b0, 8'd63, 8'd0, 9'h05A, a2);
    check("t6_accept_after_exit", a2 - last_hs, 1);
    wait_drain();

    // 5: zero wait states, back-to-back stores then loads.
    sel = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, 8'(i), 8'(8'h11 * (i + 1)), 9'h000, acc_arr[i]);
    end
    for (int i = 1; i < 4; i++) begin
      check("t5_spacing", acc_arr[i] - acc_arr[i-1], 3);
    end
    issue(1'b0, 8'd0, 8'd0, 9'h011, a1);
    issue(1'b0, 8'd1, 8'd0, 9'h022, a1);
    issue(1'b0, 8'd2, 8'd0, 9'h033, a1);
    issue(1'b0, 8'd3, 8'd0, 9'h044, a1);
    wait_drain();

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
